// File: rtl/maze_mem_arbiter_if.sv
// Solver, host and maze-memory signals shared by the arbiter and its neighbours.
// Combinational bundle: no latency; requesters hold req until ack.
interface maze_mem_arbiter_if;
  logic       s_req;
  logic       s_we;
  logic [3:0] s_x;
  logic [3:0] s_y;
  logic       s_wdata;
  logic       s_ack;
  logic       s_rdata;

  logic       h_req;
  logic       h_we;
  logic [3:0] h_x;
  logic [3:0] h_y;
  logic       h_wdata;
  logic       h_lock;
  logic       h_ack;
  logic       h_rdata;

  logic       mem_RD;
  logic       mem_WR;
  logic [3:0] mem_X;
  logic [3:0] mem_Y;
  logic       mem_Din;
  logic       mem_Dout;

  logic       busy;
  logic       starve;

  modport slave (
    input  s_req, s_we, s_x, s_y, s_wdata,
    output s_ack, s_rdata,
    input  h_req, h_we, h_x, h_y, h_wdata, h_lock,
    output h_ack, h_rdata,
    output mem_RD, mem_WR, mem_X, mem_Y, mem_Din,
    input  mem_Dout,
    output busy, starve
  );

  modport master (
    output s_req, s_we, s_x, s_y, s_wdata,
    input  s_ack, s_rdata,
    output h_req, h_we, h_x, h_y, h_wdata, h_lock,
    input  h_ack, h_rdata,
    input  mem_RD, mem_WR, mem_X, mem_Y, mem_Din,
    output mem_Dout,
    input  busy, starve
  );
endinterface

// File: rtl/maze_mem_arbiter.sv
// Round-robin arbiter for the 16x16x1 maze memory (solver vs host, host lock, starve flag).
// Write acks 2 cycles after grant, read acks 2+MEM_LAT; requesters hold req until their ack.
module maze_mem_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 64
) (
  input logic             CLK,
  input logic             RST,
  maze_mem_arbiter_if.slave bus
);

  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  localparam logic [7:0] SMAX = 8'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t     state_q, state_d;
  logic       gnt_s_q, gnt_s_d;
  logic       last_s_q, last_s_d;
  logic       we_q, we_d;
  logic [3:0] x_q, x_d;
  logic [3:0] y_q, y_d;
  logic       wd_q, wd_d;
  logic [2:0] lat_q, lat_d;
  logic       s_rdata_q, s_rdata_d;
  logic       h_rdata_q, h_rdata_d;
  logic [7:0] scnt_q, scnt_d;
  logic       starve_q, starve_d;

  logic pick_s, pick_h, solver_served;

  // The lock is only honoured at grant time, so a mid-transaction change waits for IDLE.
  assign pick_s = !bus.h_lock && bus.s_req && (!bus.h_req || !last_s_q);
  assign pick_h = bus.h_req && !pick_s;
  assign solver_served = (state_q == IDLE) ? pick_s : gnt_s_q;

  always_comb begin
    state_d   = state_q;
    gnt_s_d   = gnt_s_q;
    last_s_d  = last_s_q;
    we_d      = we_q;
    x_d       = x_q;
    y_d       = y_q;
    wd_d      = wd_q;
    lat_d     = lat_q;
    s_rdata_d = s_rdata_q;
    h_rdata_d = h_rdata_q;
    scnt_d    = scnt_q;
    starve_d  = starve_q;

    case (state_q)
      IDLE: begin
        if (pick_s) begin
          gnt_s_d  = 1'b1;
          last_s_d = 1'b1;
          we_d     = bus.s_we;
          x_d      = bus.s_x;
          y_d      = bus.s_y;
          wd_d     = bus.s_wdata;
          state_d  = ISSUE;
        end else if (pick_h) begin
          gnt_s_d  = 1'b0;
          last_s_d = 1'b0;
          we_d     = bus.h_we;
          x_d      = bus.h_x;
          y_d      = bus.h_y;
          wd_d     = bus.h_wdata;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = ACK;
        end else begin
          lat_d   = 3'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == LAT) begin
          if (gnt_s_q) s_rdata_d = bus.mem_Dout;
          else         h_rdata_d = bus.mem_Dout;
          state_d = ACK;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Saturating wait counter; the flag it raises is sticky until reset.
    if (!bus.s_req || solver_served) scnt_d = 8'd0;
    else if (scnt_q != SMAX)         scnt_d = scnt_q + 8'd1;
    if (scnt_d == SMAX) starve_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      gnt_s_q   <= 1'b0;
      last_s_q  <= 1'b0;
      we_q      <= 1'b0;
      x_q       <= 4'd0;
      y_q       <= 4'd0;
      wd_q      <= 1'b0;
      lat_q     <= 3'd0;
      s_rdata_q <= 1'b0;
      h_rdata_q <= 1'b0;
      scnt_q    <= 8'd0;
      starve_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_s_q   <= gnt_s_d;
      last_s_q  <= last_s_d;
      we_q      <= we_d;
      x_q       <= x_d;
      y_q       <= y_d;
      wd_q      <= wd_d;
      lat_q     <= lat_d;
      s_rdata_q <= s_rdata_d;
      h_rdata_q <= h_rdata_d;
      scnt_q    <= scnt_d;
      starve_q  <= starve_d;
    end
  end

  assign bus.mem_RD  = (state_q == ISSUE) && !we_q;
  assign bus.mem_WR  = (state_q == ISSUE) &&  we_q;
  assign bus.mem_X   = x_q;
  assign bus.mem_Y   = y_q;
  assign bus.mem_Din = wd_q;
  assign bus.s_ack   = (state_q == ACK) &&  gnt_s_q;
  assign bus.h_ack   = (state_q == ACK) && !gnt_s_q;
  assign bus.s_rdata = s_rdata_q;
  assign bus.h_rdata = h_rdata_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.starve  = starve_q;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed bench: instance A (MEM_LAT=1, STARVE_MAX=8) and instance B (MEM_LAT=3).
module tb_maze_mem_arbiter;

  logic clk = 1'b0;
  logic rst_a, rst_b, init_mem;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  maze_mem_arbiter_if ifa ();
  maze_mem_arbiter_if ifb ();

  maze_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(8))  dut_a (.CLK(clk), .RST(rst_a), .bus(ifa));
  maze_mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(64)) dut_b (.CLK(clk), .RST(rst_b), .bus(ifb));

  // Behavioural memories: cell (x=3,y=5) preset to 1, address {y,x}
  logic [255:0] mem_a, mem_b;
  logic         dout_a;
  logic [2:0]   pipe_b;

  always @(posedge clk) begin
    if (init_mem) begin
      mem_a <= '0;
      mem_a[8'h53] <= 1'b1;
    end else if (ifa.mem_WR) begin
      mem_a[{ifa.mem_Y, ifa.mem_X}] <= ifa.mem_Din;
    end
    dout_a <= ifa.mem_RD ? mem_a[{ifa.mem_Y, ifa.mem_X}] : 1'b0;
  end

  always @(posedge clk) begin
    if (init_mem) begin
      mem_b <= '0;
      mem_b[8'h53] <= 1'b1;
    end else if (ifb.mem_WR) begin
      mem_b[{ifb.mem_Y, ifb.mem_X}] <= ifb.mem_Din;
    end
    pipe_b <= {pipe_b[1:0], ifb.mem_RD ? mem_b[{ifb.mem_Y, ifb.mem_X}] : 1'b0};
  end

  assign ifa.mem_Dout = dout_a;
  assign ifb.mem_Dout = pipe_b[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [16:0] s_mask, h_mask;
    logic [8:0]  wr_mask, ack_mask;
    int          ov, h_cnt;

    ifa.s_req = 0; ifa.s_we = 0; ifa.s_x = 0; ifa.s_y = 0; ifa.s_wdata = 0;
    ifa.h_req = 0; ifa.h_we = 0; ifa.h_x = 0; ifa.h_y = 0; ifa.h_wdata = 0; ifa.h_lock = 0;
    ifb.s_req = 0; ifb.s_we = 0; ifb.s_x = 0; ifb.s_y = 0; ifb.s_wdata = 0;
    ifb.h_req = 0; ifb.h_we = 0; ifb.h_x = 0; ifb.h_y = 0; ifb.h_wdata = 0; ifb.h_lock = 0;
    rst_a = 1; rst_b = 1; init_mem = 1;
    step(); step();
    init_mem = 0; rst_a = 0; rst_b = 0;

    // Reset state
    chk("rst_busy",   ifa.busy, 0);
    chk("rst_starve", ifa.starve, 0);
    chk("rst_acks",   {ifa.s_ack, ifa.h_ack}, 0);
    chk("rst_strobe", {ifa.mem_RD, ifa.mem_WR}, 0);
    chk("rst_addr",   {ifa.mem_X, ifa.mem_Y, ifa.mem_Din}, 0);
    chk("rst_rdata",  {ifa.s_rdata, ifa.h_rdata}, 0);

    // T1: lone solver read of (3,5)
    ifa.s_req = 1; ifa.s_we = 0; ifa.s_x = 3; ifa.s_y = 5;
    step();
    chk("t1_c1_strobe", {ifa.mem_RD, ifa.mem_WR}, 2'b10);
    chk("t1_c1_xy",     {ifa.mem_X, ifa.mem_Y}, 8'h35);
    chk("t1_c1_busy",   ifa.busy, 1);
    step();
    chk("t1_c2_busy_ack", {ifa.busy, ifa.s_ack}, 2'b10);
    step();
    chk("t1_c3_ack",   {ifa.s_ack, ifa.h_ack, ifa.busy}, 3'b101);
    chk("t1_c3_rdata", ifa.s_rdata, 1);
    ifa.s_req = 0;
    step();
    chk("t1_c4_idle",  {ifa.busy, ifa.s_ack, ifa.s_rdata}, 3'b001);

    // T2: host writes 1 to (0,15), solver reads it back from a cleared rdata
    reset_a();
    ifa.h_req = 1; ifa.h_we = 1; ifa.h_x = 0; ifa.h_y = 15; ifa.h_wdata = 1;
    step();
    chk("t2_c1_strobe", {ifa.mem_WR, ifa.mem_RD, ifa.mem_Din}, 3'b101);
    chk("t2_c1_xy",     {ifa.mem_X, ifa.mem_Y}, 8'h0F);
    step();
    chk("t2_c2_ack", {ifa.h_ack, ifa.s_ack}, 2'b10);
    ifa.h_req = 0;
    step();
    chk("t2_c3_idle", {ifa.busy, ifa.s_rdata}, 2'b00);
    ifa.s_req = 1; ifa.s_we = 0; ifa.s_x = 0; ifa.s_y = 15;
    step(); step(); step();
    chk("t2_rd_ack",   {ifa.s_ack, ifa.h_ack}, 2'b10);
    chk("t2_rd_rdata", ifa.s_rdata, 1);
    ifa.s_req = 0;
    step();

    // T3: simultaneous held requests alternate S,H,S,H
    reset_a();
    ifa.s_req = 1; ifa.s_we = 0; ifa.s_x = 1; ifa.s_y = 1;
    ifa.h_req = 1; ifa.h_we = 0; ifa.h_x = 3; ifa.h_y = 5;
    s_mask = '0; h_mask = '0; ov = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      s_mask[i] = ifa.s_ack;
      h_mask[i] = ifa.h_ack;
      if (ifa.s_ack && ifa.h_ack) ov++;
      if (ifa.mem_RD && ifa.mem_WR) ov++;
    end
    ifa.s_req = 0; ifa.h_req = 0;
    chk("t3_s_acks", s_mask, 17'h00808);
    chk("t3_h_acks", h_mask, 17'h08080);
    chk("t3_overlap", ov, 0);
    chk("t3_rdata", {ifa.s_rdata, ifa.h_rdata}, 2'b01);
    chk("t3_starve", ifa.starve, 0);
    step();

    // T4: host lock starves the solver; starve sets at a wait count of 8
    reset_a();
    ifa.h_lock = 1; ifa.h_req = 1; ifa.h_we = 0; ifa.h_x = 1; ifa.h_y = 1;
    ifa.s_req = 1; ifa.s_we = 0; ifa.s_x = 3; ifa.s_y = 5;
    s_mask = '0; h_cnt = 0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (ifa.s_ack) s_mask[0] = 1'b1;
      if (ifa.h_ack) h_cnt++;
      if (i == 7) chk("t4_starve_c7", ifa.starve, 0);
      if (i == 8) chk("t4_starve_c8", ifa.starve, 1);
    end
    chk("t4_no_s_ack", s_mask, 0);
    chk("t4_h_acks", h_cnt, 6);
    ifa.h_lock = 0; ifa.h_req = 0;
    step(); step(); step();
    chk("t4_s_served", {ifa.s_ack, ifa.s_rdata, ifa.starve}, 3'b111);
    ifa.s_req = 0;
    step();
    chk("t4_sticky", {ifa.starve, ifa.busy}, 2'b10);

    // T5 (instance A): back-to-back solver writes, inputs changed after grant
    ifa.s_req = 1; ifa.s_we = 1; ifa.s_x = 2; ifa.s_y = 7; ifa.s_wdata = 1;
    wr_mask = '0; ack_mask = '0;
    for (int i = 1; i <= 8; i++) begin
      step();
      wr_mask[i]  = ifa.mem_WR;
      ack_mask[i] = ifa.s_ack;
      if (i == 1) begin
        chk("t5_c1_xy", {ifa.mem_X, ifa.mem_Y}, 8'h27);
        ifa.s_x = 9; ifa.s_y = 9; ifa.s_wdata = 0;
      end
      if (i == 2) chk("t5_c2_hold", {ifa.mem_X, ifa.mem_Y, ifa.mem_Din}, 9'h04F);
      if (i == 4) chk("t5_c4_xy", {ifa.mem_X, ifa.mem_Y}, 8'h99);
    end
    ifa.s_req = 0;
    chk("t5_wr_pulses", wr_mask, 9'h092);
    chk("t5_acks", ack_mask, 9'h124);
    chk("t5_mem_27", mem_a[8'h72], 1);
    chk("t5_mem_99", mem_a[8'h99], 0);
    step();

    // T6 (instance B, MEM_LAT=3): full read, then reset during WAIT
    ifb.s_req = 1; ifb.s_we = 0; ifb.s_x = 3; ifb.s_y = 5;
    s_mask = '0;
    for (int i = 1; i <= 6; i++) begin
      step();
      s_mask[i] = ifb.s_ack;
      if (i == 1) chk("t6_rd_strobe", ifb.mem_RD, 1);
      if (i == 5) ifb.s_req = 0;
    end
    chk("t6_ack_lat", s_mask, 17'h00020);
    chk("t6_rdata", ifb.s_rdata, 1);
    ifb.s_req = 1;
    step(); step();
    rst_b = 1; ifb.s_req = 0;
    step();
    rst_b = 0;
    chk("t6_rst_idle", {ifb.busy, ifb.s_ack, ifb.mem_RD, ifb.mem_WR}, 0);
    chk("t6_rst_rdata", ifb.s_rdata, 0);
    s_mask = '0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (ifb.s_ack || ifb.h_ack) s_mask[0] = 1'b1;
    end
    chk("t6_no_ack", s_mask, 0);
    ifb.s_req = 1; ifb.s_x = 3; ifb.s_y = 5;
    ifb.h_req = 1; ifb.h_we = 0; ifb.h_x = 1; ifb.h_y = 1;
    step();
    chk("t6_tie_solver", {ifb.mem_RD, ifb.mem_X, ifb.mem_Y}, 9'h135);
    step(); step(); step(); step();
    chk("t6_tie_ack", {ifb.s_ack, ifb.h_ack, ifb.s_rdata}, 3'b101);
    ifb.s_req = 0; ifb.h_req = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
